// File: rtl/pseudo_spi_mem_bridge.sv
// rtl/pseudo_spi_mem_bridge.sv - pseudo-SPI bridge between a single-port sync SRAM and an off-chip tester
//
// Purpose: DUMP mode (MODE=0) reads DATA_LEN words from SRAM starting at ADDR_BGN and
// shifts them out on SO. LOAD mode (MODE=1) shifts DATA_LEN words in on SI and writes
// them to SRAM. Bit rate (FREQ_DIV), bit order (LSB_FIRST) and a zero length are handled.
//
// Ports:
//   CLK, rst_n            clock (rising edge), asynchronous active-low reset
//   BGN                   level enable: rising edge starts, low aborts
//   MODE, LSB_FIRST       direction and bit order, sampled at start
//   ADDR_BGN, DATA_LEN    first address and word count, sampled at start
//   FREQ_DIV              SCLK half-period = FREQ_DIV+1 CLKs, sampled at start
//   SI / SO / SCLK / LAT  serial in, serial out, serial clock, end-of-frame pulse
//   PI                    SRAM read data (Q)
//   CEN, WEN, A, PO       SRAM chip enable, write enable (active low), address, write data
//   BUSY, DONE            transfer in progress, transfer complete

module pseudo_spi_mem_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  BGN,
    input  logic                  MODE,
    input  logic                  LSB_FIRST,
    input  logic [ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [LEN_WIDTH-1:0]  DATA_LEN,
    input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
    input  logic                  SI,
    input  logic [DATA_WIDTH-1:0] PI,
    output logic                  SCLK,
    output logic                  LAT,
    output logic                  SO,
    output logic                  CEN,
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] PO,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_SHIFT,
        S_WRITE,
        S_LOOP,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_bgn_d;
    logic                  r_mode;
    logic                  r_lsb;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_fdiv;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_half;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_rd_ph;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_po;
    logic                  r_so;
    logic                  r_sclk;

    logic                  w_bgn_rise;
    logic                  w_abort;
    logic                  w_frame_end;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_dump_next;
    logic [DATA_WIDTH-1:0] w_load_next;
    logic                  w_dump_first;

    // Reset value of 1 keeps a BGN that is already high at reset release from
    // looking like a rising edge.
    assign w_bgn_rise  = BGN & ~r_bgn_d;
    assign w_abort     = ~BGN && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_frame_end = (r_state == S_SHIFT) && (r_div == r_fdiv) && r_half && (r_bit == LAST_BIT);
    assign w_last      = (r_cnt == LEN_WIDTH'(1));

    // Outgoing word moves toward the SO end; incoming bits enter at the far end so the
    // first received bit lands at bit0 (LSB-first) or the MSB (MSB-first) after a full frame.
    assign w_dump_next  = r_lsb ? {1'b0, r_shift[DATA_WIDTH-1:1]} : {r_shift[DATA_WIDTH-2:0], 1'b0};
    assign w_load_next  = r_lsb ? {SI, r_shift[DATA_WIDTH-1:1]} : {r_shift[DATA_WIDTH-2:0], SI};
    assign w_dump_first = r_lsb ? w_dump_next[0] : w_dump_next[DATA_WIDTH-1];

    assign SCLK = r_sclk;
    assign SO   = r_so;
    assign A    = r_addr;
    assign PO   = r_po;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        CEN    = 1'b1;
        WEN    = 1'b1;
        LAT    = 1'b0;
        BUSY   = 1'b1;
        DONE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (w_bgn_rise) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (DATA_LEN == '0) w_next = S_DONE;
                else if (MODE)      w_next = S_SHIFT;
                else                w_next = S_READ;
            end
            S_READ: begin
                // Phase 0 issues the read; phase 1 captures Q, which is valid one CLK later.
                CEN = r_rd_ph;
                if (r_rd_ph) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_frame_end) w_next = r_mode ? S_WRITE : S_LOOP;
            end
            S_WRITE: begin
                CEN    = 1'b0;
                WEN    = 1'b0;
                w_next = S_LOOP;
            end
            S_LOOP: begin
                LAT = 1'b1;
                if (w_last)      w_next = S_DONE;
                else if (r_mode) w_next = S_SHIFT;
                else             w_next = S_READ;
            end
            S_DONE: begin
                BUSY = 1'b0;
                DONE = 1'b1;
                if (!BGN) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_bgn_d <= 1'b1;
            r_mode  <= 1'b0;
            r_lsb   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_fdiv  <= '0;
            r_div   <= '0;
            r_half  <= 1'b0;
            r_bit   <= '0;
            r_rd_ph <= 1'b0;
            r_shift <= '0;
            r_po    <= '0;
            r_so    <= 1'b0;
            r_sclk  <= 1'b0;
        end else begin
            r_bgn_d <= BGN;
            case (r_state)
                S_ADDR: begin
                    r_mode <= MODE;
                    r_lsb  <= LSB_FIRST;
                    r_addr <= ADDR_BGN;
                    r_cnt  <= DATA_LEN;
                    r_fdiv <= FREQ_DIV;
                end
                S_READ: begin
                    r_rd_ph <= ~r_rd_ph;
                    if (r_rd_ph) begin
                        r_shift <= PI;
                        r_so    <= r_lsb ? PI[0] : PI[DATA_WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    if (r_div == r_fdiv) begin
                        r_div <= '0;
                        if (!r_half) begin
                            // SCLK 0->1: this is the SI sampling CLK
                            r_half <= 1'b1;
                            r_sclk <= 1'b1;
                            if (r_mode) r_shift <= w_load_next;
                        end else begin
                            r_half <= 1'b0;
                            r_sclk <= 1'b0;
                            if (r_bit == LAST_BIT) begin
                                r_bit <= '0;
                                if (r_mode) r_po <= r_shift;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                                if (!r_mode) begin
                                    r_shift <= w_dump_next;
                                    r_so    <= w_dump_first;
                                end
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LOOP: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt - 1'b1;
                end
                default: begin
                end
            endcase
            // Abort drops any partial frame; timers restart cleanly on the next transfer.
            if (w_abort) begin
                r_sclk  <= 1'b0;
                r_half  <= 1'b0;
                r_div   <= '0;
                r_bit   <= '0;
                r_rd_ph <= 1'b0;
            end
        end
    end

endmodule
